// File: rtl/regfile_writeback.sv
// Register-file write front end: arbitrates ALU and load results into a
// registered write port and tracks outstanding load destinations.
module regfile_writeback #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned STREAK_W     = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [4:0]  load_rd,
    input  logic [31:0] load_data,
    input  logic        ld_issue_valid,
    input  logic [4:0]  ld_issue_rd,
    output logic [4:0]  write_select,
    output logic [31:0] write,
    output logic [31:0] pending
);

    localparam logic [STREAK_W-1:0] LIMIT = STREAK_W'(STARVE_LIMIT);

    logic [STREAK_W-1:0] streak;
    logic [STREAK_W-1:0] streak_nxt;
    logic                force_alu;
    logic                alu_xfer;
    logic                load_xfer;
    logic [4:0]          sel_nxt;
    logic [31:0]         data_nxt;
    logic [31:0]         pending_nxt;

    // Readies are gated by rst_n so nothing is accepted while reset is held.
    always_comb begin
        force_alu  = alu_valid && (streak >= LIMIT);
        load_ready = rst_n && !force_alu;
        alu_ready  = rst_n && !(load_valid && !force_alu);
        alu_xfer   = alu_valid && alu_ready;
        load_xfer  = load_valid && load_ready;
    end

    always_comb begin
        streak_nxt = streak;
        if (!alu_valid || alu_xfer) begin
            streak_nxt = '0;
        end else if (load_xfer && (streak < LIMIT)) begin
            streak_nxt = streak + STREAK_W'(1);
        end
    end

    always_comb begin
        sel_nxt  = '0;
        data_nxt = '0;
        if (alu_xfer && (alu_rd != 5'd0)) begin
            sel_nxt  = alu_rd;
            data_nxt = alu_data;
        end else if (load_xfer && (load_rd != 5'd0)) begin
            sel_nxt  = load_rd;
            data_nxt = load_data;
        end
    end

    // Clear before set so a same-cycle reissue keeps the register pending.
    always_comb begin
        pending_nxt = pending;
        if (load_xfer && (load_rd != 5'd0)) begin
            pending_nxt[load_rd] = 1'b0;
        end
        if (ld_issue_valid && (ld_issue_rd != 5'd0)) begin
            pending_nxt[ld_issue_rd] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak       <= '0;
            write_select <= '0;
            write        <= '0;
            pending      <= '0;
        end else begin
            streak       <= streak_nxt;
            write_select <= sel_nxt;
            write        <= data_nxt;
            pending      <= pending_nxt;
        end
    end

    a_one_grant: assert property (@(posedge clk) disable iff (!rst_n)
        !(alu_xfer && load_xfer));

endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback: vector table for arbitration,
// hand sequences for scoreboard and reset corners, queue-based write checking.
module tb_regfile_writeback;

    logic        clk;
    logic        rst_n;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        load_valid;
    logic        load_ready;
    logic [4:0]  load_rd;
    logic [31:0] load_data;
    logic        ld_issue_valid;
    logic [4:0]  ld_issue_rd;
    logic [4:0]  write_select;
    logic [31:0] write;
    logic [31:0] pending;

    regfile_writeback #(.STARVE_LIMIT(4), .STREAK_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .load_valid(load_valid), .load_ready(load_ready), .load_rd(load_rd), .load_data(load_data),
        .ld_issue_valid(ld_issue_valid), .ld_issue_rd(ld_issue_rd),
        .write_select(write_select), .write(write), .pending(pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        av;
        logic        lv;
        logic [4:0]  ard;
        logic [4:0]  lrd;
        logic [31:0] adat;
        logic [31:0] ldat;
        logic        ear;
        logic        elr;
    } vec_t;

    typedef struct {
        logic [4:0]  sel;
        logic [31:0] data;
    } exp_t;

    vec_t        tbl[$];
    exp_t        exp_q[$];
    logic [31:0] exp_pend;
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // One clock of stimulus: check readies, predict the write, then check it after the edge.
    task automatic cyc(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                       input logic iv, input logic [4:0] ird,
                       input logic ear, input logic elr);
        exp_t e;
        alu_valid = av; alu_rd = ard; alu_data = adat;
        load_valid = lv; load_rd = lrd; load_data = ldat;
        ld_issue_valid = iv; ld_issue_rd = ird;
        #1;
        chk("alu_ready", 32'(alu_ready), 32'(ear));
        chk("load_ready", 32'(load_ready), 32'(elr));
        e.sel = '0; e.data = '0;
        if (av && ear) begin
            e.sel = ard; e.data = (ard != 0) ? adat : 32'd0;
        end else if (lv && elr) begin
            e.sel = lrd; e.data = (lrd != 0) ? ldat : 32'd0;
        end
        exp_q.push_back(e);
        if (lv && elr && lrd != 0) exp_pend[lrd] = 1'b0;
        if (iv && ird != 0) exp_pend[ird] = 1'b1;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk("queue_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk("write_select", 32'(write_select), 32'(e.sel));
            chk("write", write, e.data);
        end
        chk("pending", pending, exp_pend);
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned k = 0; k < n; k++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    endtask

    function automatic vec_t mk(input logic av, input logic lv, input logic [4:0] ard,
                                input logic [4:0] lrd, input logic ear, input logic elr);
        vec_t v;
        v.av = av; v.lv = lv; v.ard = ard; v.lrd = lrd;
        v.adat = 32'hA000_0000 | 32'(ard);
        v.ldat = 32'hB000_0000 | 32'(lrd);
        v.ear = ear; v.elr = elr;
        return v;
    endfunction

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_pend = '0;
        rst_n = 1'b0;
        alu_valid = 1; alu_rd = 5'd4; alu_data = 32'h1;
        load_valid = 1; load_rd = 5'd6; load_data = 32'h2;
        ld_issue_valid = 1; ld_issue_rd = 5'd8;
        #1;
        chk("rst_alu_ready", 32'(alu_ready), 32'd0);
        chk("rst_load_ready", 32'(load_ready), 32'd0);
        @(posedge clk); #1;
        chk("rst_write_select", 32'(write_select), 32'd0);
        chk("rst_write", write, 32'd0);
        chk("rst_pending", pending, 32'd0);
        rst_n = 1'b1;
        idle(3);

        // Single ALU write, then output returns to zero.
        cyc(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 1, 1);
        idle(1);

        // Load issue, wait, then data return clears the pending bit.
        cyc(0, 0, 0, 0, 0, 0, 1, 7, 1, 1);
        idle(3);
        cyc(0, 0, 0, 1, 7, 32'h12345678, 0, 0, 0, 1);
        idle(1);

        // Arbitration table: L,L,L,L,A,L,L,L,L,A then streak-clear checks.
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 4; j++) tbl.push_back(mk(1, 1, 5'(10 + i), 5'(20 + 4 * i + j), 0, 1));
            tbl.push_back(mk(1, 1, 5'(10 + i), 5'd30, 1, 0));
        end
        tbl.push_back(mk(1, 1, 5'd12, 5'd1, 0, 1));
        tbl.push_back(mk(1, 1, 5'd12, 5'd2, 0, 1));
        tbl.push_back(mk(0, 1, 5'd12, 5'd3, 0, 1));
        for (int j = 0; j < 4; j++) tbl.push_back(mk(1, 1, 5'd13, 5'(4 + j), 0, 1));
        tbl.push_back(mk(1, 1, 5'd13, 5'd8, 1, 0));
        tbl.push_back(mk(1, 0, 5'd14, 5'd9, 1, 1));
        foreach (tbl[i])
            cyc(tbl[i].av, tbl[i].ard, tbl[i].adat, tbl[i].lv, tbl[i].lrd, tbl[i].ldat,
                0, 0, tbl[i].ear, tbl[i].elr);
        idle(1);

        // Same-cycle set and clear of r9: set wins.
        cyc(0, 0, 0, 0, 0, 0, 1, 9, 1, 1);
        cyc(0, 0, 0, 1, 9, 32'h99, 1, 9, 0, 1);
        chk("pend9_kept", 32'(pending[9]), 32'd1);
        cyc(0, 0, 0, 1, 9, 32'h999, 0, 0, 0, 1);
        // rd=0 transfers and issues never write or mark pending.
        cyc(0, 0, 0, 1, 0, 32'hFFFF_FFFF, 1, 0, 0, 1);
        cyc(1, 0, 32'hCAFE, 0, 0, 0, 0, 0, 1, 1);
        idle(1);

        // Mid-stream reset after the streak has reached the limit.
        cyc(0, 0, 0, 0, 0, 0, 1, 3, 1, 1);
        for (int j = 0; j < 4; j++) cyc(1, 1, 32'h11, 1, 5'(20 + j), 32'h22, 0, 0, 0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_write_select", 32'(write_select), 32'd0);
        chk("mid_rst_write", write, 32'd0);
        chk("mid_rst_pending", pending, 32'd0);
        chk("mid_rst_alu_ready", 32'(alu_ready), 32'd0);
        chk("mid_rst_load_ready", 32'(load_ready), 32'd0);
        @(posedge clk); #1;
        chk("mid_rst_no_write", 32'(write_select), 32'd0);
        rst_n = 1'b1;
        exp_pend = '0;
        exp_q.delete();
        cyc(1, 1, 32'h11, 1, 5'd25, 32'h55, 0, 0, 0, 1);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
